pmem_arbiter: RTL and testbench
===============================

# pmem_arbiter

Parametrised physical-memory arbiter for the next-generation memory subsystem. It multiplexes `NUM_CH` cacheline clients (for example split I-cache and D-cache) onto the single 256-bit `pmem_*` port. Arbitration is round-robin or fixed-priority, and the block holds exactly one outstanding transaction. It sits between the caches and physical memory in the top level.

## Interface
Parameters:
- `NUM_CH`, 2: number of client channels (≥1).
- `LINE_W`, 256: cacheline width in bits.
- `ADDR_W`, 32: address width.
- `MODE`, 0: 0 = round-robin, 1 = fixed priority (lowest index wins).

Ports:
- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  reset, synchronous, active-low (0 = reset).
- `ch_read`  in  NUM_CH  per-channel line read request.
- `ch_write`  in  NUM_CH  per-channel line write request.
- `ch_address`  in  NUM_CH*ADDR_W  per-channel line address; channel i at [i*ADDR_W +: ADDR_W].
- `ch_wdata`  in  NUM_CH*LINE_W  per-channel write line; channel i at [i*LINE_W +: LINE_W].
- `ch_rdata`  out  LINE_W  read line, shared by all channels, valid while `ch_resp` is high.
- `ch_resp`  out  NUM_CH  one-hot, single-cycle completion.
- `pmem_read`  out  1  memory read strobe.
- `pmem_write`  out  1  memory write strobe.
- `pmem_address`  out  ADDR_W  memory address.
- `pmem_wdata`  out  LINE_W  memory write line.
- `pmem_resp`  in  1  memory completion.
- `pmem_rdata`  in  LINE_W  memory read line, valid with `pmem_resp`.

## Operation
- FSM has three states: IDLE, BUSY, RESP.
- IDLE:
  - A channel is requesting if its `ch_read` or `ch_write` is high.
  - If any channel requests, choose grant g and latch op, address and wdata of channel g into registers. Next state BUSY.
  - If both `ch_read[g]` and `ch_write[g]` are high, the write wins.
- BUSY:
  - `pmem_read` or `pmem_write` asserted (never both); `pmem_address` and `pmem_wdata` driven from the latched registers.
  - On `pmem_resp`: latch `pmem_rdata` into the rdata register, deassert the strobe at the next edge, next state RESP.
- RESP:
  - `ch_resp[g]` = 1 for exactly one cycle; `ch_rdata` = latched line (a write returns the line from `pmem_rdata` as received, don't-care for clients).
  - Next state IDLE.
- Grant selection:
  - MODE 0: search from pointer `ptr` upward modulo NUM_CH; the first requester wins; on grant `ptr` ← (g+1) mod NUM_CH.
  - MODE 1: the lowest-index requester wins; `ptr` is unused.
- Client input changes after the grant are ignored; the transaction completes on the latched values.
- Clients must hold their request until `ch_resp` and drop it in the cycle after. The arbiter re-samples only in IDLE, so a dropped request is never regranted.
- NUM_CH=1 degenerates to a registered pass-through with the same latency.
- Fairness in MODE 0: a continuously requesting channel waits at most NUM_CH−1 other transactions.

## Timing
- Reset (`rst`=0 at an edge) sets:
  - state = IDLE, `ptr` = 0;
  - `pmem_read` = `pmem_write` = 0, `ch_resp` = 0;
  - `pmem_address`, `pmem_wdata` and `ch_rdata` = 0.
- Reset mid-transaction abandons the transaction; no `ch_resp` is issued for it. A late `pmem_resp` after reset is ignored in IDLE.
- All outputs are registered; there is no combinational path from `ch_*` or `pmem_resp` to outputs.
- Latency, with the request sampled in IDLE at cycle 0:
  - strobe high from cycle 1;
  - `pmem_resp` at cycle k ≥ 1 gives `ch_resp` at cycle k+1;
  - minimum request-to-response is 2 cycles; next grant possible at cycle k+2.
- `pmem_resp` is ignored outside BUSY.
- Strobes stay high continuously in BUSY until the edge after `pmem_resp`.

## Test plan
- Single read: NUM_CH=2, ch1 reads 0x0000_1000, memory responds 3 cycles after the strobe with line 0xA5…A5 -> `pmem_read` from cycle 1 to 3, `ch_resp`=2'b10 at cycle 4, `ch_rdata`=0xA5…A5, `ch_resp` low otherwise.
- Round-robin contention: MODE 0, ch0 and ch1 both request continuously, 1-cycle memory -> grants alternate 0,1,0,1; `pmem_address` alternates between the two channel addresses.
- Fixed priority: MODE 1, NUM_CH=4, ch1 and ch3 request -> ch1 served first; ch3 is served only after ch1 drops.
- Write pass-through: ch0 writes line 0xDEAD…BEEF to 0x0000_2000 with `ch_read` also high -> `pmem_write`=1, `pmem_read`=0, `pmem_wdata` matches; changing `ch_wdata` mid-BUSY does not alter `pmem_wdata`.
- Reset mid-operation: `rst`=0 while in BUSY -> next cycle all outputs 0 and no `ch_resp`; a `pmem_resp` pulse after reset produces no response.
- Wrap-around: MODE 0, NUM_CH=4, `ptr` at 3, requesters {0,2} -> ch0 granted; `ptr` then 1, and ch2 is granted next.

Source files
------------

// File: rtl/pmem_arbiter.sv
// rtl/pmem_arbiter.sv - round-robin / fixed-priority arbiter of cacheline clients onto one pmem port
module pmem_arbiter #(
  parameter int NUM_CH = 2,
  parameter int LINE_W = 256,
  parameter int ADDR_W = 32,
  parameter int MODE   = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH-1:0]        ch_read,
  input  logic [NUM_CH-1:0]        ch_write,
  input  logic [NUM_CH*ADDR_W-1:0] ch_address,
  input  logic [NUM_CH*LINE_W-1:0] ch_wdata,
  output logic [LINE_W-1:0]        ch_rdata,
  output logic [NUM_CH-1:0]        ch_resp,
  output logic                     pmem_read,
  output logic                     pmem_write,
  output logic [ADDR_W-1:0]        pmem_address,
  output logic [LINE_W-1:0]        pmem_wdata,
  input  logic                     pmem_resp,
  input  logic [LINE_W-1:0]        pmem_rdata
);

  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]        state;
  logic [IDX_W-1:0]  ptr;
  logic [IDX_W-1:0]  grant;
  logic [IDX_W-1:0]  grant_c;
  logic [IDX_W-1:0]  cand_c;
  logic [IDX_W-1:0]  ptr_next_c;
  logic [NUM_CH-1:0] req;
  logic              any_req;

  assign req = ch_read | ch_write;

  function automatic logic [IDX_W-1:0] wrap_idx(input int v);
    return (v >= NUM_CH) ? IDX_W'(v - NUM_CH) : IDX_W'(v);
  endfunction

  // Scan from the farthest candidate back to the nearest so the last hit is the winner.
  always_comb begin
    grant_c = '0;
    cand_c  = '0;
    any_req = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      cand_c = (MODE == 0) ? wrap_idx(int'(ptr) + i) : IDX_W'(i);
      if (req[cand_c]) begin
        grant_c = cand_c;
        any_req = 1'b1;
      end
    end
  end

  assign ptr_next_c = (grant_c == IDX_W'(NUM_CH - 1)) ? '0 : grant_c + 1'b1;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= S_IDLE;
      ptr          <= '0;
      grant        <= '0;
      pmem_read    <= 1'b0;
      pmem_write   <= 1'b0;
      pmem_address <= '0;
      pmem_wdata   <= '0;
      ch_rdata     <= '0;
      ch_resp      <= '0;
    end else begin
      ch_resp <= '0;
      case (state)
        S_IDLE: begin
          if (any_req) begin
            grant <= grant_c;
            if (MODE == 0) begin
              ptr <= ptr_next_c;
            end
            // A channel raising both read and write is treated as a write.
            pmem_write   <= ch_write[grant_c];
            pmem_read    <= ~ch_write[grant_c];
            pmem_address <= ch_address[grant_c*ADDR_W +: ADDR_W];
            pmem_wdata   <= ch_wdata[grant_c*LINE_W +: LINE_W];
            state        <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (pmem_resp) begin
            pmem_read  <= 1'b0;
            pmem_write <= 1'b0;
            ch_rdata   <= pmem_rdata;
            ch_resp    <= NUM_CH'(1) << grant;
            state      <= S_RESP;
          end
        end
        S_RESP: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pmem_arbiter.sv
// tb/tb_pmem_arbiter.sv - directed checks of pmem_arbiter in 2ch RR, 4ch fixed and 4ch RR builds
module tb_pmem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  // Instance A: two channels, round-robin
  logic [1:0]   a_read, a_write, a_resp;
  logic [63:0]  a_addr;
  logic [511:0] a_wdata;
  logic [255:0] a_rdata, a_pwdata, a_prdata;
  logic         a_pread, a_pwrite, a_presp;
  logic [31:0]  a_paddr;

  // Instance B: four channels, fixed priority
  logic [3:0]    b_read, b_write, b_resp;
  logic [127:0]  b_addr;
  logic [1023:0] b_wdata;
  logic [255:0]  b_rdata, b_pwdata, b_prdata;
  logic          b_pread, b_pwrite, b_presp;
  logic [31:0]   b_paddr;

  // Instance C: four channels, round-robin
  logic [3:0]    c_read, c_write, c_resp;
  logic [127:0]  c_addr;
  logic [1023:0] c_wdata;
  logic [255:0]  c_rdata, c_pwdata, c_prdata;
  logic          c_pread, c_pwrite, c_presp;
  logic [31:0]   c_paddr;

  pmem_arbiter #(.NUM_CH(2), .LINE_W(256), .ADDR_W(32), .MODE(0)) dut_a (
    .clk(clk), .rst(rst),
    .ch_read(a_read), .ch_write(a_write), .ch_address(a_addr), .ch_wdata(a_wdata),
    .ch_rdata(a_rdata), .ch_resp(a_resp),
    .pmem_read(a_pread), .pmem_write(a_pwrite), .pmem_address(a_paddr), .pmem_wdata(a_pwdata),
    .pmem_resp(a_presp), .pmem_rdata(a_prdata)
  );

  pmem_arbiter #(.NUM_CH(4), .LINE_W(256), .ADDR_W(32), .MODE(1)) dut_b (
    .clk(clk), .rst(rst),
    .ch_read(b_read), .ch_write(b_write), .ch_address(b_addr), .ch_wdata(b_wdata),
    .ch_rdata(b_rdata), .ch_resp(b_resp),
    .pmem_read(b_pread), .pmem_write(b_pwrite), .pmem_address(b_paddr), .pmem_wdata(b_pwdata),
    .pmem_resp(b_presp), .pmem_rdata(b_prdata)
  );

  pmem_arbiter #(.NUM_CH(4), .LINE_W(256), .ADDR_W(32), .MODE(0)) dut_c (
    .clk(clk), .rst(rst),
    .ch_read(c_read), .ch_write(c_write), .ch_address(c_addr), .ch_wdata(c_wdata),
    .ch_rdata(c_rdata), .ch_resp(c_resp),
    .pmem_read(c_pread), .pmem_write(c_pwrite), .pmem_address(c_paddr), .pmem_wdata(c_pwdata),
    .pmem_resp(c_presp), .pmem_rdata(c_prdata)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One read transaction on B or C with a 1-cycle memory; starts and ends in an IDLE cycle.
  task automatic txn4(input bit on_c, input logic [3:0] exp_resp, input logic [31:0] exp_addr,
                      input logic [255:0] line, input string tag);
    tick();
    chk({tag, " strobe"}, on_c ? c_pread : b_pread, 1'b1);
    chk({tag, " addr"}, on_c ? c_paddr : b_paddr, exp_addr);
    if (on_c) begin
      c_presp  = 1'b1;
      c_prdata = line;
    end else begin
      b_presp  = 1'b1;
      b_prdata = line;
    end
    tick();
    chk({tag, " resp"}, on_c ? c_resp : b_resp, exp_resp);
    chk({tag, " rdata"}, on_c ? c_rdata : b_rdata, line);
    chk({tag, " strobe off"}, on_c ? c_pread : b_pread, 1'b0);
    c_presp = 1'b0;
    b_presp = 1'b0;
    tick();
  endtask

  initial begin
    logic [31:0]  w;
    logic [255:0] dbeef;
    int           ch;

    dbeef = {8{32'hDEADBEEF}};
    rst = 1'b0;
    a_read = '0; a_write = '0; a_addr = '0; a_wdata = '0; a_presp = 1'b0; a_prdata = '0;
    b_read = '0; b_write = '0; b_addr = '0; b_wdata = '0; b_presp = 1'b0; b_prdata = '0;
    c_read = '0; c_write = '0; c_addr = '0; c_wdata = '0; c_presp = 1'b0; c_prdata = '0;
    tick();
    tick();
    rst = 1'b1;

    chk("rst a_pread", a_pread, 1'b0);
    chk("rst a_pwrite", a_pwrite, 1'b0);
    chk("rst a_resp", a_resp, 2'b00);
    chk("rst a_paddr", a_paddr, 32'h0);
    chk("rst a_pwdata", a_pwdata, 256'h0);
    chk("rst a_rdata", a_rdata, 256'h0);
    chk("rst b_resp", b_resp, 4'h0);
    chk("rst c_pread", c_pread, 1'b0);
    chk("rst c_ptr", dut_c.ptr, 2'd0);

    // Single read from ch1, memory answers in cycle 3
    a_read = 2'b10;
    a_addr[63:32] = 32'h0000_1000;
    tick();
    chk("rd c1 pread", a_pread, 1'b1);
    chk("rd c1 paddr", a_paddr, 32'h0000_1000);
    chk("rd c1 resp", a_resp, 2'b00);
    tick();
    chk("rd c2 pread", a_pread, 1'b1);
    chk("rd c2 resp", a_resp, 2'b00);
    tick();
    chk("rd c3 pread", a_pread, 1'b1);
    a_presp  = 1'b1;
    a_prdata = {32{8'hA5}};
    tick();
    a_presp = 1'b0;
    chk("rd c4 resp", a_resp, 2'b10);
    chk("rd c4 rdata", a_rdata, {32{8'hA5}});
    chk("rd c4 pread", a_pread, 1'b0);
    tick();
    a_read = 2'b00;
    chk("rd c5 resp", a_resp, 2'b00);
    chk("rd ptr", dut_a.ptr, 1'b0);

    // Round-robin contention with a 1-cycle memory
    a_addr = {32'h0000_0200, 32'h0000_0100};
    a_read = 2'b11;
    for (int r = 0; r < 4; r++) begin
      ch = r % 2;
      w  = 32'hC0DE_0000 + 32'(r);
      tick();
      chk("rr pread", a_pread, 1'b1);
      chk("rr paddr", a_paddr, (ch == 0) ? 32'h0000_0100 : 32'h0000_0200);
      a_presp  = 1'b1;
      a_prdata = {8{w}};
      tick();
      a_presp = 1'b0;
      chk("rr resp", a_resp, (ch == 0) ? 2'b01 : 2'b10);
      chk("rr rdata", a_rdata, {8{w}});
      tick();
    end
    a_read = 2'b00;

    // Write wins over simultaneous read; latched wdata survives client changes
    a_read  = 2'b01;
    a_write = 2'b01;
    a_addr[31:0]   = 32'h0000_2000;
    a_wdata[255:0] = dbeef;
    tick();
    chk("wr pwrite", a_pwrite, 1'b1);
    chk("wr pread", a_pread, 1'b0);
    chk("wr paddr", a_paddr, 32'h0000_2000);
    chk("wr pwdata", a_pwdata, dbeef);
    a_wdata[255:0] = '0;
    a_addr[31:0]   = 32'h0000_9999;
    tick();
    chk("wr hold pwdata", a_pwdata, dbeef);
    chk("wr hold paddr", a_paddr, 32'h0000_2000);
    chk("wr hold pwrite", a_pwrite, 1'b1);
    a_presp  = 1'b1;
    a_prdata = {16{16'h5A3C}};
    tick();
    a_presp = 1'b0;
    chk("wr resp", a_resp, 2'b01);
    chk("wr pwrite off", a_pwrite, 1'b0);
    tick();
    a_read  = 2'b00;
    a_write = 2'b00;
    chk("wr ptr", dut_a.ptr, 1'b1);

    // Reset while BUSY abandons the transaction
    a_read = 2'b01;
    a_addr[31:0]   = 32'h0000_0300;
    a_wdata[255:0] = {8{32'h1234_5678}};
    tick();
    chk("mr busy pread", a_pread, 1'b1);
    rst    = 1'b0;
    a_read = 2'b00;
    tick();
    chk("mr pread", a_pread, 1'b0);
    chk("mr pwrite", a_pwrite, 1'b0);
    chk("mr resp", a_resp, 2'b00);
    chk("mr paddr", a_paddr, 32'h0);
    chk("mr pwdata", a_pwdata, 256'h0);
    chk("mr rdata", a_rdata, 256'h0);
    chk("mr ptr", dut_a.ptr, 1'b0);
    rst      = 1'b1;
    a_presp  = 1'b1;
    a_prdata = {256{1'b1}};
    tick();
    a_presp = 1'b0;
    chk("mr late resp", a_resp, 2'b00);
    chk("mr late pread", a_pread, 1'b0);
    tick();
    chk("mr late resp2", a_resp, 2'b00);
    chk("mr late rdata", a_rdata, 256'h0);

    // Fixed priority: ch1 beats ch3 until ch1 drops
    b_addr[63:32]  = 32'h0000_1100;
    b_addr[127:96] = 32'h0000_3300;
    b_read = 4'b1010;
    txn4(1'b0, 4'b0010, 32'h0000_1100, {8{32'h1111_0001}}, "fp r0");
    txn4(1'b0, 4'b0010, 32'h0000_1100, {8{32'h1111_0002}}, "fp r1");
    b_read = 4'b1000;
    txn4(1'b0, 4'b1000, 32'h0000_3300, {8{32'h3333_0003}}, "fp r2");
    b_read = 4'b0000;

    // Round-robin wrap-around on four channels
    c_addr = {32'h0000_4000, 32'h0000_3000, 32'h0000_2000, 32'h0000_1000};
    c_read = 4'b0100;
    txn4(1'b1, 4'b0100, 32'h0000_3000, {8{32'hAAAA_0002}}, "wrap pre");
    chk("wrap ptr3", dut_c.ptr, 2'd3);
    c_read = 4'b0101;
    txn4(1'b1, 4'b0001, 32'h0000_1000, {8{32'hAAAA_0000}}, "wrap ch0");
    chk("wrap ptr1", dut_c.ptr, 2'd1);
    c_read = 4'b0100;
    txn4(1'b1, 4'b0100, 32'h0000_3000, {8{32'hAAAA_0012}}, "wrap ch2");
    chk("wrap ptr3b", dut_c.ptr, 2'd3);
    c_read = 4'b0000;
    tick();
    chk("wrap idle", c_pread, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
